// File: rtl/can_bit_destuff_if.sv
// CAN destuffer bus: sampler-side inputs plus destuffed outputs.
// master drives en/din/din_valid; slave (the destuffer) drives the rest.
interface can_bit_destuff_if #(
  parameter int CNT_W = 7
);
  logic             en;
  logic             din;
  logic             din_valid;
  logic             dout;
  logic             dout_valid;
  logic [CNT_W-1:0] bit_idx;
  logic             stuff_drop;
  logic             stuff_err;

  modport master (
    output en,
    output din,
    output din_valid,
    input  dout,
    input  dout_valid,
    input  bit_idx,
    input  stuff_drop,
    input  stuff_err
  );

  modport slave (
    input  en,
    input  din,
    input  din_valid,
    output dout,
    output dout_valid,
    output bit_idx,
    output stuff_drop,
    output stuff_err
  );
endinterface

// File: rtl/can_bit_destuff.sv
// CAN bit destuffer: drops stuff bits, tags data bits with an index.
// Ports: clk, rst (sync, active-high), bus (en/din/din_valid in; dout/dout_valid/bit_idx/stuff_drop/stuff_err out).
module can_bit_destuff #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 7
) (
  input logic              clk,
  input logic              rst,
  can_bit_destuff_if.slave bus
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    RUN,
    ERR
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  logic             dout_q, dout_d;
  logic             dv_q, dv_d;
  logic [CNT_W-1:0] bidx_q, bidx_d;
  logic             drop_q, drop_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= '0;
      prev_q  <= 1'b0;
      idx_q   <= '0;
      dout_q  <= 1'b0;
      dv_q    <= 1'b0;
      bidx_q  <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      prev_q  <= prev_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      bidx_q  <= bidx_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    prev_d  = prev_q;
    idx_d   = idx_q;
    dout_d  = 1'b0;
    dv_d    = 1'b0;
    bidx_d  = '0;
    drop_d  = 1'b0;
    err_d   = 1'b0;
    if (!bus.en) begin
      // en low wins over any coincident strobe
      state_d = IDLE;
      run_d   = '0;
      prev_d  = 1'b0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FIRST;
          run_d   = '0;
          prev_d  = 1'b0;
          idx_d   = '0;
        end
        FIRST: begin
          if (bus.din_valid) begin
            dout_d  = bus.din;
            dv_d    = 1'b1;
            bidx_d  = '0;
            prev_d  = bus.din;
            run_d   = RUN_W'(1);
            idx_d   = CNT_W'(1);
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.din_valid) begin
            if (run_q == RUN_MAX) begin
              if (bus.din != prev_q) begin
                // stuff bit opens the next run
                drop_d = 1'b1;
                prev_d = bus.din;
                run_d  = RUN_W'(1);
              end else begin
                err_d   = 1'b1;
                state_d = ERR;
              end
            end else begin
              if (bus.din == prev_q) begin
                run_d = run_q + RUN_W'(1);
              end else begin
                run_d  = RUN_W'(1);
                prev_d = bus.din;
              end
              dout_d = bus.din;
              dv_d   = 1'b1;
              bidx_d = idx_q;
              if (idx_q != IDX_MAX) begin
                idx_d = idx_q + CNT_W'(1);
              end
            end
          end
        end
        ERR: begin
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.bit_idx    = bidx_q;
  assign bus.stuff_drop = drop_q;
  assign bus.stuff_err  = err_q;

endmodule

// File: tb/tb_can_bit_destuff.sv
// Bench for can_bit_destuff: vector table, corner sequences, random run.
// Two DUTs (CNT_W 7 and 3) share stimulus; a history-queue model predicts outputs.
module tb_can_bit_destuff;

  localparam int SL = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  can_bit_destuff_if #(.CNT_W(7)) b7 ();
  can_bit_destuff_if #(.CNT_W(3)) b3 ();

  assign b3.en        = b7.en;
  assign b3.din       = b7.din;
  assign b3.din_valid = b7.din_valid;

  can_bit_destuff #(.STUFF_LEN(SL), .CNT_W(7)) u7 (
    .clk (clk),
    .rst (rst),
    .bus (b7)
  );

  can_bit_destuff #(.STUFF_LEN(SL), .CNT_W(3)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  int n_vec = 0;
  int n_bad = 0;

  // model state: raw bits of the current run window, frame flags
  bit m_active = 0;
  bit m_err    = 0;
  bit hist[$];
  int m_emit   = 0;

  bit x_dout, x_dv, x_drop, x_err;
  int x_idx;

  int c_dv, c_drop, c_err;
  int idx3_log[$];

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic m_clear();
    m_active = 0;
    m_err    = 0;
    hist.delete();
    m_emit   = 0;
  endtask

  task automatic model(input bit r, e, d, v);
    bit all_eq;
    x_dout = 0;
    x_dv   = 0;
    x_drop = 0;
    x_err  = 0;
    x_idx  = 0;
    if (r || !e) begin
      m_clear();
    end else if (!m_active) begin
      m_active = 1;
    end else if (!m_err && v) begin
      all_eq = (hist.size() >= SL);
      if (all_eq)
        foreach (hist[i])
          if (hist[i] != hist[0]) all_eq = 0;
      if (all_eq) begin
        if (d != hist[$]) begin
          x_drop = 1;
          hist.push_back(d);
        end else begin
          x_err = 1;
          m_err = 1;
        end
      end else begin
        x_dv   = 1;
        x_dout = d;
        x_idx  = m_emit;
        m_emit++;
        hist.push_back(d);
      end
      while (hist.size() > SL) void'(hist.pop_front());
    end
  endtask

  task automatic chk(input string nm);
    int e7, e3;
    e7 = sat(x_idx, 127);
    e3 = sat(x_idx, 7);
    n_vec++;
    if (b7.dout_valid !== x_dv || b7.stuff_drop !== x_drop ||
        b7.stuff_err !== x_err ||
        (x_dv && (b7.dout !== x_dout ||
                  int'(b7.bit_idx) != e7))) begin
      n_bad++;
      $display("FAIL %s w7: got dv=%b d=%b i=%0d dr=%b er=%b want dv=%b d=%b i=%0d dr=%b er=%b",
        nm, b7.dout_valid, b7.dout, b7.bit_idx, b7.stuff_drop,
        b7.stuff_err, x_dv, x_dout, e7, x_drop, x_err);
    end
    n_vec++;
    if (b3.dout_valid !== x_dv || b3.stuff_drop !== x_drop ||
        b3.stuff_err !== x_err ||
        (x_dv && (b3.dout !== x_dout ||
                  int'(b3.bit_idx) != e3))) begin
      n_bad++;
      $display("FAIL %s w3: got dv=%b d=%b i=%0d dr=%b er=%b want dv=%b d=%b i=%0d dr=%b er=%b",
        nm, b3.dout_valid, b3.dout, b3.bit_idx, b3.stuff_drop,
        b3.stuff_err, x_dv, x_dout, e3, x_drop, x_err);
    end
  endtask

  task automatic step(input bit r, e, d, v, input string nm);
    rst          = r;
    b7.en        = e;
    b7.din       = d;
    b7.din_valid = v;
    @(posedge clk);
    model(r, e, d, v);
    #1;
    chk(nm);
    if (b7.dout_valid) c_dv++;
    if (b7.stuff_drop) c_drop++;
    if (b7.stuff_err) c_err++;
    if (b3.dout_valid) idx3_log.push_back(int'(b3.bit_idx));
  endtask

  task automatic cnt_clr();
    c_dv   = 0;
    c_drop = 0;
    c_err  = 0;
    idx3_log.delete();
  endtask

  task automatic cmp(input string nm, input int got, want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic bits(input string nm, input bit b[$]);
    foreach (b[i]) step(0, 1, b[i], 1, nm);
  endtask

  typedef struct {
    bit r, e, d, v;
    bit xd, xv;
    int xi;
    bit xdr, xer;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, e, d, v, xd, xv,
                     input int xi, input bit xdr, xer);
    vec_t t;
    t.r = r; t.e = e; t.d = d; t.v = v;
    t.xd = xd; t.xv = xv; t.xi = xi;
    t.xdr = xdr; t.xer = xer;
    tbl.push_back(t);
  endtask

  initial begin
    bit last;
    bit b[$];
    int k;
    b7.en        = 0;
    b7.din       = 0;
    b7.din_valid = 0;
    cnt_clr();

    // reset, then 0,1,0,1,1,0
    add(1,0,0,0, 0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,1, 0,1,0,0,0);
    add(0,1,1,1, 1,1,1,0,0);
    add(0,1,0,1, 0,1,2,0,0);
    add(0,1,1,1, 1,1,3,0,0);
    add(0,1,1,1, 1,1,4,0,0);
    add(0,1,0,1, 0,1,5,0,0);
    add(0,0,0,0, 0,0,0,0,0);
    // 0 x5, stuff 1, 0
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,1, 0,1,0,0,0);
    add(0,1,0,1, 0,1,1,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,1, 0,1,2,0,0);
    add(0,1,0,1, 0,1,3,0,0);
    add(0,1,0,1, 0,1,4,0,0);
    add(0,1,1,1, 0,0,0,1,0);
    add(0,1,0,1, 0,1,5,0,0);
    add(0,0,0,0, 0,0,0,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].v, "tbl");
      n_vec++;
      if (b7.dout_valid !== tbl[i].xv ||
          b7.stuff_drop !== tbl[i].xdr ||
          b7.stuff_err !== tbl[i].xer ||
          (tbl[i].xv && (b7.dout !== tbl[i].xd ||
                         int'(b7.bit_idx) != tbl[i].xi))) begin
        n_bad++;
        $display("FAIL tbl[%0d]: got dv=%b d=%b i=%0d dr=%b er=%b want dv=%b d=%b i=%0d dr=%b er=%b",
          i, b7.dout_valid, b7.dout, b7.bit_idx, b7.stuff_drop,
          b7.stuff_err, tbl[i].xv, tbl[i].xd, tbl[i].xi,
          tbl[i].xdr, tbl[i].xer);
      end
    end

    // stuff bit counts toward the next run
    cnt_clr();
    step(0, 1, 0, 0, "s3");
    b = '{1,1,1,1,1,0,0,0,0,0,1};
    bits("s3", b);
    step(0, 0, 0, 0, "s3");
    cmp("s3_dv", c_dv, 9);
    cmp("s3_drop", c_drop, 2);

    // stuff error, ignored bits, re-enable
    cnt_clr();
    step(0, 1, 0, 0, "s4");
    b = '{1,1,1,1,1,1,0,1,0};
    bits("s4", b);
    cmp("s4_err", c_err, 1);
    cmp("s4_dv", c_dv, 5);
    step(0, 0, 0, 0, "s4");
    step(0, 1, 0, 0, "s4");
    step(0, 1, 0, 1, "s4");
    cmp("s4_new_dv", int'(b7.dout_valid), 1);
    cmp("s4_new_idx", int'(b7.bit_idx), 0);

    // reset mid-frame
    step(0, 1, 1, 1, "s5");
    step(0, 1, 1, 1, "s5");
    step(1, 1, 1, 1, "s5");
    cmp("s5_quiet", int'(b7.dout_valid | b7.stuff_drop |
                         b7.stuff_err), 0);
    step(0, 0, 0, 0, "s5");
    step(0, 1, 0, 0, "s5");
    step(0, 1, 1, 1, "s5");
    cmp("s5_idx", int'(b7.bit_idx), 0);

    // en drop coincident with a strobe after run of 4
    step(0, 0, 0, 0, "s6");
    step(0, 1, 0, 0, "s6");
    b = '{0,0,0,0};
    bits("s6", b);
    step(0, 0, 0, 1, "s6");
    cmp("s6_drop_dv", int'(b7.dout_valid), 0);
    step(0, 1, 0, 0, "s6");
    step(0, 1, 0, 1, "s6");
    cmp("s6_dv", int'(b7.dout_valid), 1);
    cmp("s6_idx", int'(b7.bit_idx), 0);
    cmp("s6_nodrop", int'(b7.stuff_drop), 0);

    // saturation on the narrow instance
    step(0, 0, 0, 0, "s7");
    cnt_clr();
    step(0, 1, 0, 0, "s7");
    b = '{0,1,0,1,0,1,0,1,0,1};
    bits("s7", b);
    cmp("s7_n", idx3_log.size(), 10);
    for (int i = 0; i < 10; i++) begin
      k = (i < idx3_log.size()) ? idx3_log[i] : -1;
      cmp("s7_idx", k, sat(i, 7));
    end

    // random frames against the model
    last = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r, e, d, v;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 49) != 0);
      v = $urandom_range(0, 1) == 1;
      d = ($urandom_range(0, 9) < 7) ? last : ~last;
      if (v) last = d;
      step(r, e, d, v, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/can_bit_destuff.md
Name: can_bit_destuff

Overview:
- Sits directly downstream of the mid-bit sampler in the CAN receive path.
- Consumes one sampled bit per sampler valid pulse and removes CAN stuff bits: after STUFF_LEN consecutive equal bits, the next bit is a stuff bit.
- Forwards only destuffed bits, each tagged with its index within the frame, to the field decoder.
- Flags a stuff error when a stuff bit has the same polarity as the preceding run; the bit-stuffed region is SOF through the end of the CRC sequence.

Parameters:
- STUFF_LEN, 5, run length of equal bits after which the next bit is a stuff bit.
- CNT_W, 7, width of the destuffed-bit index output; the index saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  synchronous, active-high reset.
- en  input  1  high from SOF until the end of the CRC sequence; the same enable that drives the sampler.
- din  input  1  sampled bit from the sampler.
- din_valid  input  1  one-cycle strobe; din is valid in this cycle.
- dout  output  1  destuffed bit.
- dout_valid  output  1  one-cycle strobe qualifying dout and bit_idx.
- bit_idx  output  CNT_W  index of the bit on dout; SOF = 0.
- stuff_drop  output  1  one-cycle pulse when a stuff bit is discarded.
- stuff_err  output  1  one-cycle pulse on a stuff-rule violation.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: all outputs are 0, state is IDLE, run_cnt = 0, prev = 0, idx = 0. Reset asserted mid-frame aborts immediately, with no further output pulses.
- Outputs are registered. dout_valid, stuff_drop or stuff_err assert exactly 1 cycle after the din_valid that caused them. At most one of the three is high in any cycle.
- States: IDLE, FIRST, RUN, ERR.
- IDLE:
  - Outputs held 0 and counters cleared.
  - en = 1 -> FIRST.
- FIRST:
  - On din_valid: emit din with bit_idx = 0, set prev = din, run_cnt = 1, idx = 1 -> RUN.
- RUN, on din_valid:
  - If run_cnt == STUFF_LEN and din != prev: stuff bit. Pulse stuff_drop with no dout_valid. Set prev = din, run_cnt = 1; the stuff bit starts the next run. idx unchanged.
  - If run_cnt == STUFF_LEN and din == prev: pulse stuff_err with no dout_valid -> ERR.
  - Otherwise, if din == prev: run_cnt + 1.
  - Otherwise: run_cnt = 1, prev = din.
  - In both non-stuff cases, emit dout = din with bit_idx = idx, then idx + 1, saturating at 2^CNT_W-1.
- ERR: all inputs ignored; no pulses until en = 0.
- en = 0 in any state -> IDLE next cycle.
  - If din_valid coincides with en = 0, the bit is discarded and en wins.
  - run_cnt, prev and idx are cleared.
  - Outputs are 0 in the following cycle. A pulse already registered from the previous cycle still completes its single cycle.
- en re-asserting one cycle after dropping starts a fresh frame from FIRST.
- run_cnt width is clog2(STUFF_LEN+1). run_cnt never exceeds STUFF_LEN.
- din_valid while en = 1 in IDLE, which can only occur on the cycle en rises, is ignored; the sampler cannot strobe before its half-bit point.

Test Plan:
- Bits 0,1,0,1,1,0 with en high, then en low -> six dout_valid pulses, dout matches input, bit_idx 0..5, no stuff_drop or stuff_err.
- Bits 0,0,0,0,0,1,0 -> five outputs of 0 (idx 0-4), then stuff_drop on the 1 with no dout, then dout = 0 at idx 5; the run after the stuff bit restarts at 1.
- Bits 1,1,1,1,1,0,0,0,0,0,1 -> stuff bit 0 is dropped and counts toward the next run, so the following four 0s plus the stuff bit reach 5. The trailing 1 is therefore a second stuff_drop. Total of 9 dout pulses, idx 0-8.
- Bits 1×5 then 1 -> stuff_err pulse exactly once, no dout for that bit. Further din_valid pulses give no outputs until en falls. After re-enable, the bit sequence 0 emits at idx 0.
- rst high for one cycle mid-frame after 3 bits -> all outputs 0 next cycle. The next frame (en low then high) starts at idx 0 with run_cnt reset.
- en falls in the same cycle as din_valid -> no dout_valid for that bit. The next frame's first bit is emitted at idx 0 with no stuff action, even if the prior run was 4 long.
- With CNT_W = 3, 10 non-stuffed bits -> bit_idx sequence 0..7,7,7 (saturation).
